sram_like_arbiter: RTL and testbench

Two-master arbiter that shares one sram-like memory port between the IF stage instruction requester and the MEM stage data requester. It sits between the CPU pipeline and the memory-side bridge, and allows one transaction in flight at a time. Data requests have fixed priority, and a starvation guard periodically forces an instruction grant. Both requester ports and the memory port use the team's req/addr_ok/data_ok sram-like handshake.

---
 rtl/sram_like_arbiter_if.sv | 52 +++++
 rtl/sram_like_arbiter.sv | 114 +++++++++++
 tb/tb_sram_like_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_arbiter_if.sv
// Shared sram-like bus bundle: IF and MEM requester ports
// plus the memory-side port of the two-master arbiter.
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size,
    input  data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size,
    output mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size,
    output data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size,
    input  mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter: data has priority, one
// transaction in flight, starvation guard for inst.
module sram_like_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  sram_like_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              own_q, own_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              gnt_i, gnt_d;
  logic              fin;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      own_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_i   = 1'b0;
    gnt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Requests present while reset is held never win.
        if (!reset) begin
          gnt_i = bus.inst_req &&
                  (!bus.data_req || cnt_q == LIMIT);
          gnt_d = bus.data_req && !gnt_i;
        end
        if (gnt_i) begin
          state_d = ADDR;
          own_d   = 1'b0;
          wr_d    = 1'b0;
          size_d  = 2'b10;
          addr_d  = bus.inst_addr;
          wdata_d = '0;
          cnt_d   = '0;
        end else if (gnt_d) begin
          state_d = ADDR;
          own_d   = 1'b1;
          wr_d    = bus.data_wr;
          size_d  = bus.data_size;
          addr_d  = bus.data_addr;
          wdata_d = bus.data_wdata;
          if (!bus.inst_req)
            cnt_d = '0;
          else if (cnt_q != LIMIT)
            cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ADDR: if (bus.mem_addr_ok) state_d = DATA;
      DATA: if (bus.mem_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.inst_addr_ok = gnt_i;
  assign bus.data_addr_ok = gnt_d;

  assign bus.mem_req   = (state_q == ADDR);
  assign bus.mem_wr    = wr_q;
  assign bus.mem_size  = size_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // An in-flight transaction hit by reset never completes.
  assign fin = (state_q == DATA) && bus.mem_data_ok &&
               !reset;

  assign bus.inst_data_ok = fin && !own_q;
  assign bus.data_data_ok = fin && own_q;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: directed
// scenarios, then randomized traffic with random resets.
module tb_sram_like_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  sram_like_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int   la_k = -1, ld_k = -1;
  int   noise_pct = 20;
  bit   fix_rd = 0;
  logic [31:0] rd_val = '0;
  int   mph = 0;
  int   mcnt = 0, la = 0, ld = 0;
  bit   aok_r = 0, dok_r = 0;

  initial begin
    bit rs;
    ifc.mem_addr_ok = 1'b0;
    ifc.mem_data_ok = 1'b0;
    ifc.mem_rdata   = '0;
    forever begin
      @(negedge clk);
      rs = reset;
      @(posedge clk); #1;
      if (rs) mph = 0;
      else if (mph == 1 && aok_r) begin
        mph = 2; mcnt = 0;
        ld = (ld_k < 0) ? $urandom_range(0, 3) : ld_k;
      end else if (mph == 2 && dok_r) mph = 0;
      if (mph == 0 && ifc.mem_req) begin
        mph = 1; mcnt = 0;
        la = (la_k < 0) ? $urandom_range(0, 3) : la_k;
      end
      aok_r = 0; dok_r = 0;
      if (mph == 1) begin aok_r = (mcnt >= la); mcnt++; end
      if (mph == 2) begin dok_r = (mcnt >= ld); mcnt++; end
      ifc.mem_addr_ok = aok_r || (mph != 1 &&
        $urandom_range(0, 99) < noise_pct);
      ifc.mem_data_ok = dok_r || (mph != 2 &&
        $urandom_range(0, 99) < noise_pct);
      ifc.mem_rdata = fix_rd ? rd_val : $urandom;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic        own;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  bit   have = 0;
  int   stg = 0;
  txn_t cur;
  int   starve = 0;
  logic sb[$];
  byte  glog[$];

  always @(negedge clk) begin
    bit ei, ed;
    logic o;
    if (reset) begin
      chk("rst_iaok", 32'(ifc.inst_addr_ok), 0);
      chk("rst_daok", 32'(ifc.data_addr_ok), 0);
      chk("rst_idok", 32'(ifc.inst_data_ok), 0);
      chk("rst_ddok", 32'(ifc.data_data_ok), 0);
      have = 0; starve = 0; sb.delete();
    end else begin
      ei = !have && ifc.inst_req &&
           (!ifc.data_req || starve == SL);
      ed = !have && ifc.data_req && !ei;
      chk("inst_addr_ok", 32'(ifc.inst_addr_ok), 32'(ei));
      chk("data_addr_ok", 32'(ifc.data_addr_ok), 32'(ed));
      chk("mem_req", 32'(ifc.mem_req), 32'(have && stg == 1));
      if (have && stg == 1) begin
        chk("mem_wr", 32'(ifc.mem_wr), 32'(cur.wr));
        chk("mem_size", 32'(ifc.mem_size), 32'(cur.size));
        chk("mem_addr", ifc.mem_addr, cur.addr);
        chk("mem_wdata", ifc.mem_wdata, cur.wdata);
      end
      chk("inst_data_ok", 32'(ifc.inst_data_ok),
          32'(have && stg == 2 && ifc.mem_data_ok && !cur.own));
      chk("data_data_ok", 32'(ifc.data_data_ok),
          32'(have && stg == 2 && ifc.mem_data_ok && cur.own));
      if (ifc.inst_data_ok || ifc.data_data_ok) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: got data_ok expected none");
        end else begin
          o = sb.pop_front();
          chk("sb_owner", 32'(ifc.data_data_ok), 32'(o));
          chk("sb_rdata", o ? ifc.data_rdata : ifc.inst_rdata,
              ifc.mem_rdata);
        end
      end
      if (have) begin
        if (stg == 1 && ifc.mem_addr_ok) stg = 2;
        else if (stg == 2 && ifc.mem_data_ok) have = 0;
      end
      if (ei || ed) begin
        have = 1; stg = 1;
        cur.own   = ed;
        cur.wr    = ed ? ifc.data_wr : 1'b0;
        cur.size  = ed ? ifc.data_size : 2'd2;
        cur.addr  = ed ? ifc.data_addr : ifc.inst_addr;
        cur.wdata = ed ? ifc.data_wdata : 32'h0;
        sb.push_back(ed);
        glog.push_back(ed ? "D" : "I");
        if (ed && ifc.inst_req)
          starve = (starve < SL) ? starve + 1 : SL;
        else
          starve = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_dok(input bit d, input int lim,
                          input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (d ? ifc.data_data_ok : ifc.inst_data_ok) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: got timeout expected data_ok", nm);
    end
  endtask

  task automatic outs_zero(input string nm);
    chk({nm, "_mreq"}, 32'(ifc.mem_req), 0);
    chk({nm, "_iaok"}, 32'(ifc.inst_addr_ok), 0);
    chk({nm, "_daok"}, 32'(ifc.data_addr_ok), 0);
    chk({nm, "_idok"}, 32'(ifc.inst_data_ok), 0);
    chk({nm, "_ddok"}, 32'(ifc.data_data_ok), 0);
  endtask

  task automatic rnd_inst(input bit acc);
    if (ifc.inst_req && !acc) begin
      if ($urandom_range(0, 15) == 0) ifc.inst_req = 1'b0;
    end else begin
      ifc.inst_req  = ($urandom_range(0, 99) < 40);
      ifc.inst_addr = $urandom & 32'hffff_fffc;
    end
  endtask

  task automatic rnd_data(input bit acc);
    if (ifc.data_req && !acc) begin
      if ($urandom_range(0, 15) == 0) ifc.data_req = 1'b0;
    end else begin
      ifc.data_req   = ($urandom_range(0, 99) < 40);
      ifc.data_wr    = 1'($urandom);
      ifc.data_size  = 2'($urandom_range(0, 2));
      ifc.data_addr  = $urandom;
      ifc.data_wdata = $urandom;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int   ic, n, k, g0;
    bit   ia, da, ok;
    string exp_g;
    ifc.inst_req   = 1'b1;
    ifc.inst_addr  = 32'hbfc0_0000;
    ifc.data_req   = 1'b0;
    ifc.data_wr    = 1'b0;
    ifc.data_size  = 2'd0;
    ifc.data_addr  = '0;
    ifc.data_wdata = '0;
    reset = 1'b1;
    repeat (2) tick();
    ifc.inst_req = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    outs_zero("post_rst");

    // single inst read
    la_k = 1; ld_k = 1; fix_rd = 1; rd_val = 32'h2401_0001;
    tick();
    ifc.inst_req  = 1'b1;
    ifc.inst_addr = 32'hbfc0_0000;
    @(negedge clk);
    chk("t1_iaok", 32'(ifc.inst_addr_ok), 1);
    tick();
    ifc.inst_req = 1'b0;
    @(negedge clk);
    chk("t1_mreq", 32'(ifc.mem_req), 1);
    chk("t1_maddr", ifc.mem_addr, 32'hbfc0_0000);
    chk("t1_mwr", 32'(ifc.mem_wr), 0);
    chk("t1_msize", 32'(ifc.mem_size), 2);
    wait_dok(0, 20, "t1_dok");
    chk("t1_rdata", ifc.inst_rdata, 32'h2401_0001);

    // simultaneous requests
    fix_rd = 0;
    tick();
    ifc.inst_req   = 1'b1;
    ifc.inst_addr  = 32'hbfc0_0004;
    ifc.data_req   = 1'b1;
    ifc.data_wr    = 1'b1;
    ifc.data_size  = 2'd2;
    ifc.data_addr  = 32'h0000_1000;
    ifc.data_wdata = 32'hdead_beef;
    @(negedge clk);
    chk("t2_daok", 32'(ifc.data_addr_ok), 1);
    chk("t2_iaok", 32'(ifc.inst_addr_ok), 0);
    tick();
    ifc.data_req = 1'b0;
    @(negedge clk);
    chk("t2_mwr", 32'(ifc.mem_wr), 1);
    chk("t2_mwdata", ifc.mem_wdata, 32'hdead_beef);
    wait_dok(1, 20, "t2_ddok");
    @(negedge clk);
    chk("t2_iaok_next", 32'(ifc.inst_addr_ok), 1);
    tick();
    ifc.inst_req = 1'b0;
    wait_dok(0, 20, "t2_idok");

    // starvation guard
    la_k = 0; ld_k = 0;
    g0 = glog.size();
    tick();
    ifc.inst_req  = 1'b1;
    ifc.data_req  = 1'b1;
    ifc.data_wr   = 1'b0;
    ifc.data_size = 2'd1;
    ic = 0;
    for (int c = 0; c < 300 && ic < 2; c++) begin
      @(negedge clk);
      ia = ifc.inst_addr_ok;
      da = ifc.data_addr_ok;
      tick();
      if (ia) begin
        ic++;
        ifc.inst_addr = ifc.inst_addr + 32'd4;
        if (ic == 2) ifc.inst_req = 1'b0;
      end
      if (da) begin
        ifc.data_addr  = $urandom;
        ifc.data_wdata = $urandom;
      end
    end
    ifc.data_req = 1'b0;
    chk("t3_inst_grants", ic, 2);
    repeat (20) tick();
    exp_g = "DDDDIDDDDI";
    for (int i = 0; i < 10; i++) begin
      if (g0 + i < glog.size())
        chk("t3_order", 32'(glog[g0 + i]), 32'(exp_g[i]));
      else begin
        checks++; errors++;
        $display("FAIL t3_order: got none expected %c",
                 exp_g[i]);
      end
    end

    // memory stalls
    la_k = 5; ld_k = 7;
    tick();
    ifc.data_req  = 1'b1;
    ifc.data_wr   = 1'b0;
    ifc.data_size = 2'd1;
    ifc.data_addr = 32'h0000_2002;
    @(negedge clk);
    chk("t4_daok", 32'(ifc.data_addr_ok), 1);
    tick();
    ifc.data_req = 1'b0;
    ifc.inst_req = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!ifc.mem_req) break;
      n++;
    end
    chk("t4_addr_cycles", n, 6);
    k = 1; ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (ifc.data_data_ok) begin ok = 1; break; end
      @(negedge clk);
      k++;
    end
    chk("t4_data_cycles", k, 8);
    @(negedge clk);
    chk("t4_iaok_after", 32'(ifc.inst_addr_ok), 1);
    tick();
    ifc.inst_req = 1'b0;
    wait_dok(0, 40, "t4_idok");

    // spurious memory strobes in IDLE
    noise_pct = 100;
    repeat (8) begin
      @(negedge clk);
      chk("t5_idle_idok", 32'(ifc.inst_data_ok), 0);
      chk("t5_idle_ddok", 32'(ifc.data_data_ok), 0);
    end
    noise_pct = 20;

    // reset while in DATA
    la_k = 0; ld_k = 10;
    tick();
    ifc.inst_req  = 1'b1;
    ifc.inst_addr = 32'hbfc0_0100;
    tick();
    ifc.inst_req = 1'b0;
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mph == 2) begin ok = 1; break; end
    end
    chk("t5_reach_data", 32'(ok), 1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    outs_zero("t5_post_rst");
    la_k = 0; ld_k = 1; fix_rd = 1; rd_val = 32'h1234_5678;
    tick();
    ifc.inst_req  = 1'b1;
    ifc.inst_addr = 32'hbfc0_0200;
    @(negedge clk);
    chk("t5_iaok", 32'(ifc.inst_addr_ok), 1);
    tick();
    ifc.inst_req = 1'b0;
    wait_dok(0, 20, "t5_idok");
    chk("t5_rdata", ifc.inst_rdata, 32'h1234_5678);
    fix_rd = 0;

    // randomized traffic
    la_k = -1; ld_k = -1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      ia = ifc.inst_addr_ok;
      da = ifc.data_addr_ok;
      tick();
      reset = ($urandom_range(0, 599) == 0);
      rnd_inst(ia);
      rnd_data(da);
    end
    reset = 1'b0;
    ifc.inst_req = 1'b0;
    ifc.data_req = 1'b0;
    repeat (40) tick();
    chk("drain_sb", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
